// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the Basys 3 display.
// A divided scan clock arrives as plain data. Each of its rising edges steps
// the display one digit to the left. The inputs are re-sampled once per full
// scan, so a digit never mixes old and new data.
module seg7_scan_driver #(
    parameter bit LZ_SUPPRESS = 1'b0
) (
    input  logic        clockin,
    input  logic        resetn,
    input  logic        scan_clk,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic        s1_q, s2_q, s3_q;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] valueSnap_q, valueSnap_d;
    logic [3:0]  blankSnap_q, blankSnap_d;
    logic [3:0]  dpSnap_q, dpSnap_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic        wrap;
    logic [3:0]  nibble;
    logic        upperZero;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hexDecode(input logic [3:0] n);
        case (n)
            4'h0:    hexDecode = 7'b1000000;
            4'h1:    hexDecode = 7'b1111001;
            4'h2:    hexDecode = 7'b0100100;
            4'h3:    hexDecode = 7'b0110000;
            4'h4:    hexDecode = 7'b0011001;
            4'h5:    hexDecode = 7'b0010010;
            4'h6:    hexDecode = 7'b0000010;
            4'h7:    hexDecode = 7'b1111000;
            4'h8:    hexDecode = 7'b0000000;
            4'h9:    hexDecode = 7'b0010000;
            4'hA:    hexDecode = 7'b0001000;
            4'hB:    hexDecode = 7'b0000011;
            4'hC:    hexDecode = 7'b1000110;
            4'hD:    hexDecode = 7'b0100001;
            4'hE:    hexDecode = 7'b0000110;
            default: hexDecode = 7'b0001110;
        endcase
    endfunction

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

    // Step the digit index on each tick, and re-sample the inputs on the tick
    // that wraps 3 -> 0. The outputs for the new slot come from the next-state
    // snapshot, so digit 0 already uses the freshly captured inputs.
    always_comb begin
        tick        = s2_q & ~s3_q;
        wrap        = tick && (idx_q == 2'd3);
        idx_d       = idx_q;
        valueSnap_d = valueSnap_q;
        blankSnap_d = blankSnap_q;
        dpSnap_d    = dpSnap_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;

        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
        if (wrap) begin
            valueSnap_d = value;
            blankSnap_d = blank;
            dpSnap_d    = dp_in;
        end

        nibble = valueSnap_d[{idx_d, 2'b00} +: 4];
        case (idx_d)
            2'd1:    upperZero = (valueSnap_d[15:4] == 12'h000);
            2'd2:    upperZero = (valueSnap_d[15:8] == 8'h00);
            2'd3:    upperZero = (valueSnap_d[15:12] == 4'h0);
            default: upperZero = 1'b0;
        endcase

        if (tick) begin
            if (blankSnap_d[idx_d]) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = (LZ_SUPPRESS && upperZero) ? 7'b1111111 : hexDecode(nibble);
                dp_d  = ~dpSnap_d[idx_d];
            end
        end
    end

    // Synchronize the scan clock, keep one history flop for edge detection,
    // and hold the scan state. Reset parks idx at 3 so that the first tick
    // wraps to digit 0 and takes a fresh snapshot.
    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            idx_q       <= 2'd3;
            valueSnap_q <= 16'h0000;
            blankSnap_q <= 4'b0000;
            dpSnap_q    <= 4'b0000;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            s1_q        <= scan_clk;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            idx_q       <= idx_d;
            valueSnap_q <= valueSnap_d;
            blankSnap_q <= blankSnap_d;
            dpSnap_q    <= dpSnap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter LZ_SUPPRESS, default 0; 1 enables leading-zero suppression.
REQ-002 clockin  input  1  system clock (Basys 3 100 MHz); all flops on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 scan_clk  input  1  divided clock from the n-bit clock divider; treated as data, never used as a clock.
REQ-005 value  input  16  four hex nibbles; digit i = value[4i+3:4i].
REQ-006 blank  input  4  per-digit force-off mask, 1 = digit dark.
REQ-007 dp_in  input  4  per-digit decimal point request, 1 = lit.
REQ-008 an  output  4  anode enables, active-low, at most one low.
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point cathode, active-low.

Function
REQ-011 scan_clk SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; tick = s2 AND NOT s3.
REQ-012 Tick latency: scan_clk first sampled high at edge k -> tick high during cycle after edge k+1 -> outputs update at edge k+2; one tick per scan_clk rising edge.
REQ-013 Digit index idx (2 bits) SHALL advance idx+1 mod 4 on each tick; 3 -> 0 wraps; hold otherwise.
REQ-014 On a tick with idx==3, snapshot registers SHALL capture value, blank, dp_in; digit 0 shown at that same edge uses the newly captured inputs (no tearing within a scan).
REQ-015 an, seg, dp SHALL be registered and updated on the same edge as idx, reflecting the new idx; an = all ones except bit idx low.
REQ-016 Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 Snapshot blank[idx]=1 -> an=1111, seg=1111111, dp=1 for that slot (takes priority over all other rules).
REQ-018 LZ_SUPPRESS=1: digit i>=1 SHALL display seg=1111111, dp per REQ-019, an still low, when nibbles i..3 are all zero; digit 0 never suppressed.
REQ-019 dp = NOT snapshot dp_in[idx] unless blanked.
REQ-020 scan_clk static -> no ticks; all outputs and idx hold indefinitely.
REQ-021 scan_clk high or low pulses shorter than one clockin period may be missed; no requirement applies.
REQ-022 value/blank/dp_in changes between wraps SHALL NOT affect outputs until the next idx 3->0 tick.

Reset
REQ-023 resetn low SHALL immediately (asynchronously) force: an=1111, seg=1111111, dp=1, idx=3, s1=s2=s3=0, snapshots=0.
REQ-024 After resetn rises, first tick wraps idx 3->0 and captures snapshots; no output change before that tick.
REQ-025 Reset asserted mid-scan SHALL abort without any partial-digit output on the cycle following deassertion.

Verification
REQ-026 Reset, value=16'h1234, blank=0, dp_in=0, four scan_clk pulses -> an sequence 1110/1101/1011/0111 with seg 0110000? no: digit0=4 0011001, digit1=3 0110000, digit2=2 0100100, digit3=1 1111001; each change exactly 2 clockin edges after scan_clk sampled high.
REQ-027 value changed to 16'hBEEF while idx=1 -> digits 2,3 still show 2,1; after wrap digit0 shows F=0001110.
REQ-028 LZ_SUPPRESS=1, value=16'h0005 -> digit0 seg=0010010, digits 1-3 seg=1111111 with an low; value=16'h0000 -> digit0 shows 1000000.
REQ-029 blank=4'b0100, dp_in=4'b0001 -> slot 2 an=1111, seg=1111111, dp=1; slot 0 dp=0.
REQ-030 resetn pulsed low while idx=2 -> outputs dark same cycle (async); after release first tick shows digit 0 with new snapshot.
REQ-031 scan_clk held high 1000 cycles -> exactly one advance; held low -> none.
